// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary-to-BCD converter (iterative shift-add-3),
//               one IN_W-bit value to DIGITS decimal digits per conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int          IN_W    = 32,
    parameter int          DIGITS  = 8,
    parameter int unsigned MAX_VAL = 99999999
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [IN_W-1:0] i_bin,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_ovf,
    output logic [6:0]      o_digit0,
    output logic [6:0]      o_digit1,
    output logic [6:0]      o_digit2,
    output logic [6:0]      o_digit3,
    output logic [6:0]      o_digit4,
    output logic [6:0]      o_digit5,
    output logic [6:0]      o_digit6,
    output logic [6:0]      o_digit7
);

    localparam int               CNT_W       = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int               SCR_W       = 4 * DIGITS;
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(IN_W - 1);
    localparam logic [IN_W-1:0]  C_MAX       = IN_W'(MAX_VAL);
    localparam logic [SCR_W-1:0] C_ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [IN_W-1:0]    bin_q,      bin_d;
    logic [SCR_W-1:0]   scr_q,      scr_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [SCR_W-1:0]   digits_q,   digits_d;
    logic               ovf_q,      ovf_d;
    logic               done_q,     done_d;
    logic [SCR_W-1:0]   w_scr_adj;

    // Add-3 correction on every nibble, applied to pre-shift values in parallel
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            assign w_scr_adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ?
                                         (scr_q[4*g +: 4] + 4'd3) :
                                          scr_q[4*g +: 4];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    bin_d      = i_bin;
                    scr_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (i_bin > C_MAX);
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scr_d = {w_scr_adj[SCR_W-2:0], bin_q[IN_W-1]};
                bin_d = {bin_q[IN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Saturated inputs display all nines regardless of scratch contents
                digits_d = ovf_pend_q ? C_ALL_NINES : scr_q;
                ovf_d    = ovf_pend_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = done_q;
    assign o_ovf    = ovf_q;
    assign o_digit0 = {3'b000, digits_q[ 3: 0]};
    assign o_digit1 = {3'b000, digits_q[ 7: 4]};
    assign o_digit2 = {3'b000, digits_q[11: 8]};
    assign o_digit3 = {3'b000, digits_q[15:12]};
    assign o_digit4 = {3'b000, digits_q[19:16]};
    assign o_digit5 = {3'b000, digits_q[23:20]};
    assign o_digit6 = {3'b000, digits_q[27:24]};
    assign o_digit7 = {3'b000, digits_q[31:28]};

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Scoreboard testbench for bin2bcd_seq with a decimal
//               arithmetic reference model and cycle-exact timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int unsigned C_MAX = 99999999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] bin;
    logic        busy, done, ovf;
    logic [6:0]  d0, d1, d2, d3, d4, d5, d6, d7;

    always #5 clk = ~clk;

    bin2bcd_seq #(.IN_W(32), .DIGITS(8), .MAX_VAL(99999999)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_bin    (bin),
        .o_busy   (busy),
        .o_done   (done),
        .o_ovf    (ovf),
        .o_digit0 (d0),
        .o_digit1 (d1),
        .o_digit2 (d2),
        .o_digit3 (d3),
        .o_digit4 (d4),
        .o_digit5 (d5),
        .o_digit6 (d6),
        .o_digit7 (d7)
    );

    typedef struct {
        int          acc;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          free_at = 0;
    logic [55:0] cur_exp = '0;
    logic        cur_ovf = 1'b0;
    logic        done_exp, busy_exp;
    logic        end_req = 1'b0;
    logic        end_ack = 1'b0;
    exp_t        popped;

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal digits by repeated division; saturated values show all nines
    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        if (v > C_MAX) return {8{4'h9}};
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [55:0] widen(input logic [31:0] n);
        logic [55:0] w;
        for (int i = 0; i < 8; i++) w[7*i +: 7] = {3'b000, n[4*i +: 4]};
        return w;
    endfunction

    task automatic chk(input string name, input logic [55:0] act, input logic [55:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Monitor: compares every cycle against the scoreboard-derived expectation
    always @(negedge clk) begin
        done_exp = 1'b0;
        busy_exp = 1'b0;
        if (!rst_n) begin
            cur_exp = '0;
            cur_ovf = 1'b0;
        end else if (sb.size() > 0) begin
            busy_exp = (cyc >= sb[0].acc) && (cyc < sb[0].acc + 33);
            if (cyc == sb[0].acc + 33) begin
                done_exp = 1'b1;
                popped   = sb.pop_front();
                cur_exp  = widen(ref_bcd(popped.val));
                cur_ovf  = (popped.val > C_MAX);
            end
        end
        chk("done",   {55'd0, done}, {55'd0, done_exp});
        chk("busy",   {55'd0, busy}, {55'd0, busy_exp});
        chk("digits", {d7, d6, d5, d4, d3, d2, d1, d0}, cur_exp);
        chk("ovf",    {55'd0, ovf},  {55'd0, cur_ovf});
        if (end_req && !end_ack) begin
            chk("sb_empty", 56'(sb.size()), 56'd0);
            end_ack = 1'b1;
        end
    end

    // Drives one cycle; predicts acceptance from the bench's own timing model
    task automatic drive(input logic s, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = s;
        bin   = b;
        if (s && rst_n && (cyc + 1 >= free_at)) begin
            sb.push_back('{acc: cyc + 1, val: b});
            free_at = cyc + 1 + 34;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        sb.delete();
        free_at = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 999));
            1:       return 32'($urandom_range(99999990, 100000010));
            2:       return $urandom;
            default: return 32'($urandom_range(0, 99999999));
        endcase
    endfunction

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        bin   = '0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        drive(1'b1, 32'd0);
        idle(40);
        drive(1'b1, 32'd12345678);
        idle(33 + 50);
        drive(1'b1, 32'd99999999);
        idle(35);
        drive(1'b1, 32'd100000000);
        idle(35);
        drive(1'b1, 32'd7);
        idle(35);

        drive(1'b1, 32'd42);
        idle(9);
        drive(1'b1, 32'd999);
        idle(30);

        drive(1'b1, 32'd5);
        for (int i = 0; i < 34; i++) drive(1'b1, 32'd9876);
        idle(40);

        drive(1'b1, 32'd12345678);
        idle(40);
        drive(1'b1, 32'd55555555);
        idle(14);
        do_reset(3);
        drive(1'b1, 32'd10);
        idle(40);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] v;
            v = pick_val();
            if ($urandom_range(0, 1) == 1) begin
                drive(1'b1, v);
            end else begin
                int hold;
                hold = $urandom_range(1, 40);
                for (int k = 0; k < hold; k++) drive(1'b1, ($urandom_range(0, 3) == 0) ? pick_val() : v);
            end
            idle($urandom_range(0, 40));
            if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 3));
        end

        idle(40);
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_ack; i++) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative shift-add-3 (double-dabble).
- Sits directly upstream of the seven-segment decoder stage. Converts the 32-bit value written by the LSU to the display register into eight decimal digits.
- Each digit drives one of the decoder's 7-bit io_hexN_o inputs.
- Start/busy/done handshake; results held stable between conversions.

Parameters:
IN_W, 32, width of binary input; shift count per conversion equals IN_W
DIGITS, 8, number of BCD digits produced; fixed at 8 for this port list
MAX_VAL, 99999999, largest value representable; inputs above it saturate

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  request conversion; sampled only in IDLE
i_bin  input  IN_W  unsigned binary value; captured on accepted start
o_busy  output  1  high while a conversion is in progress (state != IDLE)
o_done  output  1  one-cycle pulse, registered, coincident with new digit values
o_ovf  output  1  latched: last converted i_bin exceeded MAX_VAL
o_digit0..o_digit7  output  7 each  BCD digit, 0 = least significant; bits [6:4] always 0, bits [3:0] in 0..9

Behaviour:
- Reset (asynchronous, i_rst_n=0): state=IDLE; o_busy=0, o_done=0, o_ovf=0, all o_digitN=0. Internal shift and scratch registers and counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with i_start=1: capture i_bin into the binary shift register.
  - Clear the 4*DIGITS-bit BCD scratch register and set counter=0.
  - Latch ovf_pending = (i_bin > MAX_VAL).
  - Go to SHIFT.
- SHIFT: each edge does two things:
  - For each scratch nibble >= 5, add 3 (all nibbles in parallel, using pre-shift values).
  - Shift {scratch, bin} left by 1, with the bin MSB entering the scratch LSB.
  - Counter increments. The edge performing shift number IN_W (counter == IN_W-1) moves to DONE.
- DONE: on the next edge:
  - Load o_digitN = {3'b000, scratch nibble N}.
  - If ovf_pending, load every digit = 9 instead and set o_ovf=1; otherwise set o_ovf=0.
  - Set o_done=1 and move to IDLE.
  - o_done clears on the following edge.
- Timing, with the start accepted at edge 0:
  - Shifts occur at edges 1..IN_W (1..32).
  - Outputs and o_done update at edge IN_W+1 (33).
  - o_busy is high from after edge 0 until edge 33.
  - The earliest next start is accepted at edge 34, so throughput is one conversion per 34 cycles.
- i_start while o_busy=1 is ignored and not queued. i_bin changes after capture have no effect.
- o_digitN and o_ovf hold their values until the next DONE, and never show partial results.
- Counter width: ceil(log2(IN_W)). There is no wrap-around, because SHIFT exits at IN_W-1.
- Reset asserted mid-conversion aborts immediately: all outputs return to reset values and the next conversion needs a fresh start.
- Every scratch nibble stays within 0..9 after each shift for inputs <= MAX_VAL. For saturated inputs, scratch overflow bits beyond DIGITS are discarded; the saturation rule determines the outputs.

Test Plan:
- Reset, then i_start with i_bin=0 -> o_busy high for 33 cycles, o_done pulses once at edge 33, all digits 0, o_ovf=0.
- i_bin=12345678 -> o_digit7..0 = 1,2,3,4,5,6,7,8 at edge 33; values hold over 50 idle cycles.
- i_bin=99999999 then i_bin=100000000 -> first gives all digits 9 with o_ovf=0; second gives all digits 9 with o_ovf=1. Then i_bin=7 -> digits 0000_0007, o_ovf=0.
- Start with i_bin=42; pulse i_start with i_bin=999 at edge 10; change i_bin mid-conversion -> single o_done, result 42; second start ignored.
- Back-to-back: i_start held high continuously with i_bin=5, then 9876 -> conversions accepted at edges 0 and 34, o_done at 33 and 67, results 5 and 9876.
- Conversion of 12345678 to completion, then i_bin=55555555 with i_rst_n low at edge 15 -> o_busy=0, digits 0, o_done never pulses; a subsequent start with 10 yields digits 0000_0010.
